dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port 2048x8 data memory, which has a synchronous read and a write-enabled write on the same port.
- Requesters:
  - Port 0: the AVR core's load/store path.
  - Port 1: a secondary master (DMA/debug loader).
- The CPU has priority. An anti-starvation counter forces a DMA grant after a bounded number of contended cycles.
- Read data returns one cycle after grant, tagged to its owner. A losing CPU access raises stall back to the core.

Parameters:
- ADDR_W, 11, data memory address width.
- DATA_W, 8, data width.
- MAX_HOLD, 4, consecutive contended CPU wins before one forced DMA grant (range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request not granted this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write/read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdata  out  DATA_W  DMA read data.
- dma_rvalid  out  1  dma_rdata valid.
- mem_addr  out  ADDR_W  to memory address.
- mem_we  out  1  to memory write enable.
- mem_wdata  out  DATA_W  to memory data input.
- mem_rdata  in  DATA_W  from memory registered read data.
- perf_stall_cnt  out  16  CPU stall cycles (optional feature).
- perf_dma_cnt  out  16  DMA grants (optional feature).

Behaviour:
- Grant is combinational from requests plus registered state. The memory port is driven combinationally from the winner in the same cycle.
- Arbitration, per cycle:
  - Neither requesting: no grant; mem_we=0; mem_addr/mem_wdata hold the CPU values.
  - Only CPU: CPU granted; cpu_stall=0.
  - Only DMA: DMA granted; dma_gnt=1.
  - Both, state PRI_CPU: CPU granted; cpu_stall=0; dma_gnt=0; starve_cnt increments.
  - Both, state FORCE_DMA: DMA granted; cpu_stall=1.
- FSM (2 states):
  - PRI_CPU -> FORCE_DMA when a contended CPU win brings starve_cnt to MAX_HOLD.
  - FORCE_DMA -> PRI_CPU unconditionally after one cycle; starve_cnt cleared.
  - starve_cnt clears in PRI_CPU on any cycle where dma_req=0 or DMA is granted.
  - If dma_req drops while in FORCE_DMA, the CPU is granted normally and the FSM still returns to PRI_CPU.
- cpu_stall = cpu_req & ~cpu_granted. It is never 1 when cpu_req=0.
- Read return:
  - A granted read (we=0) sets a registered owner tag. In the following cycle the owner's rvalid=1.
  - rdata = mem_rdata for both ports, qualified only by the rvalid flags.
  - Writes produce no rvalid.
  - Back-to-back reads to alternating owners yield alternating rvalid with no bubble.
- Write/read same address in consecutive cycles: memory semantics apply. The read returns the newly written value, because the memory reads after the write is registered in the following cycle.
- Reset:
  - Asynchronous.
  - Registered outputs forced immediately to reset values: cpu_rvalid=0, dma_rvalid=0, FSM=PRI_CPU, starve_cnt=0, perf counters=0.
  - While RST=1: mem_we=0, dma_gnt=0, cpu_stall=0.
  - A read granted in the cycle reset asserts never returns rvalid.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle cpu_stall=1.
  - perf_dma_cnt increments on every dma_gnt.
  - Both counters saturate at 16'hFFFF and clear on RST.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared package holds:
  - owner tag constants: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2;
  - FSM state constants: PRI_CPU, FORCE_DMA;
  - default DMEM_ADDR_W=11 and DMEM_DATA_W=8.
- One natural sub-module: dmem_arb_perf, holding the two saturating counters, instantiated only under DMEM_ARB_PERF_EN.

Test Plan:
- CPU-only read: cpu_req=1, we=0, addr=0x010, ram[0x010]=0x5A -> mem_addr=0x010 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0x5A; cpu_stall=0 throughout.
- DMA-only write then CPU read: DMA writes 0x3C to 0x7FF -> dma_gnt=1, mem_we=1; the CPU then reads 0x7FF -> cpu_rdata=0x3C one cycle later.
- Continuous contention, MAX_HOLD=4, both requesting reads for 10 cycles:
  - CPU granted cycles 0-3 and DMA granted cycle 4 (cpu_stall=1 only then).
  - The pattern repeats: DMA again at cycle 9.
  - rvalid owners match the grants, one cycle delayed.
- dma_req deasserted exactly in the FORCE_DMA cycle -> CPU granted, no stall, FSM back to PRI_CPU, starve_cnt=0.
- RST asserted mid-read (grant in cycle N, RST at N+0.5) -> cpu_rvalid stays 0, mem_we=0 during reset; after release, the first CPU request is granted immediately.
- With DMEM_ARB_PERF_EN: run 3 forced DMA grants plus 2 DMA-only accesses -> perf_stall_cnt=3, perf_dma_cnt=5; without the macro both read 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 8;
  localparam int STARVE_W    = 4;
  localparam int PERF_W      = 16;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  typedef enum logic [0:0] {
    PRI_CPU   = 1'b0,
    FORCE_DMA = 1'b1
  } arb_state_e;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arb_perf.sv
// ============================================================================
// Module      : dmem_arb_perf
// Description : Saturating CPU-stall and DMA-grant event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_perf
  import dmem_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_inc,
  input  logic              dma_inc,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_dma_cnt
);

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] dma_cnt_q, dma_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dma_cnt_d   = dma_cnt_q;
    if (stall_inc && (stall_cnt_q != {PERF_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (dma_inc && (dma_cnt_q != {PERF_W{1'b1}}))     dma_cnt_d   = dma_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      dma_cnt_q   <= dma_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_dma_cnt   = dma_cnt_q;

endmodule : dmem_arb_perf

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : CPU-priority arbiter for the single-port data memory with
//               anti-starvation DMA grant. Optional counters: DMEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_dma_cnt
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d, starve_inc;
  logic [1:0]          owner_q, owner_d;
  logic                cpu_gnt;
  logic                contended;

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    contended = cpu_req & dma_req;
    dma_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    if (!RST) begin
      dma_gnt = dma_req & (~cpu_req | (state_q == FORCE_DMA));
      cpu_gnt = cpu_req & ~dma_gnt;
    end
    cpu_stall = cpu_req & ~cpu_gnt & ~RST;

    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_gnt & cpu_we;
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  // FORCE_DMA lasts exactly one cycle; every other path clears the count.
  always_comb begin
    state_d      = PRI_CPU;
    starve_cnt_d = '0;
    starve_inc   = starve_cnt_q + 1'b1;
    if ((state_q == PRI_CPU) && contended && cpu_gnt) begin
      starve_cnt_d = starve_inc;
      if (starve_inc == STARVE_W'(MAX_HOLD)) state_d = FORCE_DMA;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)      owner_d = OWN_CPU;
    else if (dma_gnt && !dma_we) owner_d = OWN_DMA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= PRI_CPU;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign dma_rvalid = (owner_q == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .CLK            (CLK),
    .RST            (RST),
    .stall_inc      (cpu_stall),
    .dma_inc        (dma_gnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_dma_cnt   (perf_dma_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_dma_cnt   = '0;
`endif

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomized and directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [15:0]   perf_stall_cnt, perf_dma_cnt;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
  );

  always #5 CLK = ~CLK;

  // Memory attached to the DUT: registered read, read-before-write.
  logic [DW-1:0] ram [0:2047];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [DW-1:0] model_ram [0:2047];
  int            m_hold   = 0;
  bit            m_forced = 1'b0;
  int            m_pend   = 0;     // 0 none, 1 cpu, 2 dma
  logic [DW-1:0] m_pdata  = '0;
  int            m_stalls = 0;
  int            m_dmas   = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input bit cr, input bit cw, input int ca, input int cd,
                        input bit dr, input bit dw, input int da, input int dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = DW'(cd);
    dma_req = dr; dma_we = dw; dma_addr = AW'(da); dma_wdata = DW'(dd);
  endtask

  // Checks the current cycle's outputs against the model, then advances the model.
  task automatic compare();
    bit dwin, cwin, exp_we;
    int exp_ps, exp_pd;
`ifdef DMEM_ARB_PERF_EN
    exp_ps = m_stalls; exp_pd = m_dmas;
`else
    exp_ps = 0; exp_pd = 0;
`endif
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(exp_ps));
    check("perf_dma_cnt", 32'(perf_dma_cnt), 32'(exp_pd));
    if (RST) begin
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_dma_gnt", 32'(dma_gnt), 0);
      check("rst_cpu_stall", 32'(cpu_stall), 0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("rst_dma_rvalid", 32'(dma_rvalid), 0);
      m_hold = 0; m_forced = 0; m_pend = 0; m_stalls = 0; m_dmas = 0;
      return;
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
    check("dma_rvalid", 32'(dma_rvalid), 32'(m_pend == 2));
    if (m_pend == 1) check("cpu_rdata", 32'(cpu_rdata), 32'(m_pdata));
    if (m_pend == 2) check("dma_rdata", 32'(dma_rdata), 32'(m_pdata));

    dwin   = dma_req && (!cpu_req || m_forced);
    cwin   = cpu_req && !dwin;
    exp_we = dwin ? dma_we : (cwin && cpu_we);
    check("dma_gnt", 32'(dma_gnt), 32'(dwin));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cwin));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(dwin ? dma_addr : cpu_addr));
    if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(dwin ? dma_wdata : cpu_wdata));

    m_pend = 0;
    if (cwin && !cpu_we) begin m_pend = 1; m_pdata = model_ram[cpu_addr]; end
    if (dwin && !dma_we) begin m_pend = 2; m_pdata = model_ram[dma_addr]; end
    if (cwin && cpu_we) model_ram[cpu_addr] = cpu_wdata;
    if (dwin && dma_we) model_ram[dma_addr] = dma_wdata;
    if (cpu_req && !cwin && m_stalls < 65535) m_stalls++;
    if (dwin && m_dmas < 65535) m_dmas++;

    if (m_forced) begin
      m_forced = 0; m_hold = 0;
    end else if (cpu_req && dma_req) begin
      m_hold++;
      if (m_hold == MH) m_forced = 1;
    end else begin
      m_hold = 0;
    end
  endtask

  task automatic cyc_cmp();
    @(negedge CLK);
    compare();
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_cmp();
    adv();
  endtask

  logic [9:0] gv, sv;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]       = DW'(i * 37 + 11);
      model_ram[i] = DW'(i * 37 + 11);
    end
    ram[11'h010] = 8'h5A;
    model_ram[11'h010] = 8'h5A;

    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    // Requests presented during reset must be ignored.
    set_in(1, 1, 5, 1, 1, 1, 6, 2);
    cyc_cmp();
    check("lit_rst_mem_we", 32'(mem_we), 0);
    check("lit_rst_stall", 32'(cpu_stall), 0);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    idle_cycle();

    // CPU-only read of 0x010
    set_in(1, 0, 'h010, 0, 0, 0, 0, 0);
    cyc_cmp();
    check("lit_cpu_rd_addr", 32'(mem_addr), 32'h010);
    check("lit_cpu_rd_stall", 32'(cpu_stall), 0);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_cmp();
    check("lit_cpu_rd_valid", 32'(cpu_rvalid), 1);
    check("lit_cpu_rd_data", 32'(cpu_rdata), 32'h5A);
    adv();

    // DMA-only write, then CPU reads it back
    set_in(0, 0, 0, 0, 1, 1, 'h7FF, 'h3C);
    cyc_cmp();
    check("lit_dma_wr_gnt", 32'(dma_gnt), 1);
    check("lit_dma_wr_we", 32'(mem_we), 1);
    adv();
    set_in(1, 0, 'h7FF, 0, 0, 0, 0, 0);
    cyc_cmp();
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_cmp();
    check("lit_wr_rd_data", 32'(cpu_rdata), 32'h3C);
    adv();

    // Continuous contention: DMA forced on cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 'h100 + i, 0, 1, 0, 'h200 + i, 0);
      cyc_cmp();
      gv[i] = dma_gnt;
      sv[i] = cpu_stall;
      adv();
    end
    check("lit_contend_gnt", 32'(gv), 32'b10_0001_0000);
    check("lit_contend_stall", 32'(sv), 32'b10_0001_0000);
    idle_cycle();

    // DMA withdraws exactly in the forced cycle
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, i, 0, 1, 0, 'h40 + i, 0);
      cyc_cmp();
      adv();
    end
    set_in(1, 0, 9, 0, 0, 0, 0, 0);
    cyc_cmp();
    check("lit_drop_stall", 32'(cpu_stall), 0);
    adv();
    set_in(1, 0, 10, 0, 1, 0, 'h50, 0);
    cyc_cmp();
    check("lit_drop_after_gnt", 32'(dma_gnt), 0);
    check("lit_drop_after_stall", 32'(cpu_stall), 0);
    adv();
    idle_cycle();

    // Reset asserted mid-cycle after a CPU read grant
    set_in(1, 0, 'h020, 0, 0, 0, 0, 0);
    cyc_cmp();
    #1 RST = 1'b1;
    adv();
    cyc_cmp();
    check("lit_rst_rd_rvalid", 32'(cpu_rvalid), 0);
    check("lit_rst_rd_we", 32'(mem_we), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 RST = 1'b0;
    adv();
    set_in(1, 0, 'h021, 0, 0, 0, 0, 0);
    cyc_cmp();
    check("lit_post_rst_stall", 32'(cpu_stall), 0);
    check("lit_post_rst_addr", 32'(mem_addr), 32'h021);
    adv();
    idle_cycle();

    // Perf scenario: 3 forced DMA grants plus 2 DMA-only accesses
    RST = 1'b1;
    cyc_cmp();
    adv();
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      set_in(1, 0, i, 0, 1, 0, i + 1, 0);
      cyc_cmp();
      adv();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 1, 0, 'h30 + i, 0);
      cyc_cmp();
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc_cmp();
`ifdef DMEM_ARB_PERF_EN
    check("lit_perf_stall", 32'(perf_stall_cnt), 3);
    check("lit_perf_dma", 32'(perf_dma_cnt), 5);
`else
    check("lit_perf_stall", 32'(perf_stall_cnt), 0);
    check("lit_perf_dma", 32'(perf_dma_cnt), 0);
`endif
    adv();

    // Randomized traffic over a narrow address window to force collisions
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
             $urandom_range(0, 255), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15), $urandom_range(0, 255));
      cyc_cmp();
      adv();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dmem_arbiter

`default_nettype wire
